// File: rtl/sipo_row_feeder_pkg.sv
// Shared types and constants for the SIPO row feeder: FSM state encoding, read latency
// and the counter-width helper.
package sipo_row_feeder_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned IF_WIDTH     = 4;
  localparam int unsigned KERNEL_WIDTH = 3;
  localparam int unsigned READ_LATENCY = 1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StFetch,
    StDrain,
    StDone
  } feed_state_e;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int unsigned c_log_2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/sipo_row_feeder_if.sv
// Row-buffer read port: single-word reads, data returned one cycle after rd_en.
interface sipo_row_feeder_if
  import sipo_row_feeder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned IN_WIDTH   = DATA_WIDTH * IF_WIDTH
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [IN_WIDTH-1:0]   rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/sipo_feed_pipe.sv
// Two-stage delay line aligning row tags with returned buffer data; drives the shift bar's
// serial word, first-word pulse and latch pulse.
module sipo_feed_pipe #(
  parameter int unsigned IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue,
  input  logic                first,
  input  logic                last,
  input  logic                pad,
  input  logic [IN_WIDTH-1:0] rd_data,
  output logic [IN_WIDTH-1:0] in_serial,
  output logic                begin_serial_in,
  output logic                refresh_parallel_array,
  output logic                drain_hit
);
  logic                s1_valid_q, s1_first_q, s1_last_q, s1_pad_q;
  logic [IN_WIDTH-1:0] ser_q;
  logic                begin_q, s2_last_q, refresh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_pad_q   <= 1'b0;
      ser_q      <= '0;
      begin_q    <= 1'b0;
      s2_last_q  <= 1'b0;
      refresh_q  <= 1'b0;
    end else begin
      // Stage 1 lines the tags up with rd_data arriving after the read latency.
      s1_valid_q <= issue;
      s1_first_q <= first;
      s1_last_q  <= last;
      s1_pad_q   <= pad;
      if (s1_valid_q) ser_q <= s1_pad_q ? '0 : rd_data;
      begin_q    <= s1_valid_q & s1_first_q;
      s2_last_q  <= s1_valid_q & s1_last_q;
      refresh_q  <= s2_last_q;
    end
  end

  assign in_serial              = ser_q;
  assign begin_serial_in        = begin_q;
  assign refresh_parallel_array = refresh_q;
  assign drain_hit              = s2_last_q;
endmodule

// File: rtl/sipo_row_feeder.sv
// Row-fetch controller feeding the SIPO shift bar. Optional zero-row padding around the
// region is enabled by defining SIPO_FEED_ZERO_PAD_EN.
module sipo_row_feeder
  import sipo_row_feeder_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = DATA_WIDTH * IF_WIDTH,
  parameter int unsigned NUM        = KERNEL_WIDTH,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ROW_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  input  logic [ROW_WIDTH-1:0]  num_rows,
  input  logic                  consumer_ready,
  output logic                  busy,
  output logic                  done,
  sipo_row_feeder_if.master     rd_bus,
  output logic [IN_WIDTH-1:0]   in_serial,
  output logic                  begin_serial_in,
  output logic                  refresh_parallel_array
);
  localparam int unsigned KW  = c_log_2(NUM);
  localparam int unsigned RCW = ROW_WIDTH + 1;  // room for the two pad rows

  feed_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_ptr_q, row_ptr_d, stride_q, stride_d;
  logic [RCW-1:0]        total_q, total_d, row_q, row_d, total_start;
  logic [KW-1:0]         k_q, k_d;
  logic                  done_q;
  logic                  issue, pad_row, last_word, last_row, drain_hit;

`ifdef SIPO_FEED_ZERO_PAD_EN
  assign total_start = RCW'(num_rows) + RCW'(2);
  assign pad_row     = (row_q == '0) || last_row;
`else
  assign total_start = RCW'(num_rows);
  assign pad_row     = 1'b0;
`endif

  assign last_word = (k_q == KW'(NUM - 1));
  assign last_row  = (row_q == total_q - RCW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      row_ptr_q <= '0;
      stride_q  <= '0;
      total_q   <= '0;
      row_q     <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      stride_q  <= stride_d;
      total_q   <= total_d;
      row_q     <= row_d;
      k_q       <= k_d;
      done_q    <= (state_q == StDone);
    end
  end

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    stride_d  = stride_q;
    total_d   = total_q;
    row_d     = row_q;
    k_d       = k_q;
    issue     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_ptr_d = base_addr;
          stride_d  = row_stride;
          total_d   = total_start;
          row_d     = '0;
          k_d       = '0;
          state_d   = (total_start == '0) ? StDone : StWait;
        end
      end
      StWait: begin
        // Word 0 goes out in the same cycle the consumer signals ready.
        if (consumer_ready) begin
          issue   = 1'b1;
          k_d     = KW'(1);
          state_d = StFetch;
        end
      end
      StFetch: begin
        issue = 1'b1;
        if (last_word) begin
          k_d   = '0;
          row_d = row_q + RCW'(1);
          if (!pad_row) row_ptr_d = row_ptr_q + stride_q;
          if (last_row)             state_d = StDrain;
          else if (!consumer_ready) state_d = StWait;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDrain: begin
        // Final word is on in_serial; its refresh fires as DONE is entered.
        if (drain_hit) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign rd_bus.rd_en   = issue & ~pad_row;
  assign rd_bus.rd_addr = row_ptr_q + ADDR_WIDTH'(k_q);

  sipo_feed_pipe #(
    .IN_WIDTH(IN_WIDTH)
  ) u_pipe (
    .clk                    (clk),
    .reset                  (reset),
    .issue                  (issue),
    .first                  (k_q == '0),
    .last                   (last_word),
    .pad                    (pad_row),
    .rd_data                (rd_bus.rd_data),
    .in_serial              (in_serial),
    .begin_serial_in        (begin_serial_in),
    .refresh_parallel_array (refresh_parallel_array),
    .drain_hit              (drain_hit)
  );
endmodule

// File: tb/tb_sipo_row_feeder.sv
// Self-checking bench for sipo_row_feeder: per-cycle expectations built from a row
// schedule derived from the ready pattern, with a random-content row buffer.
module tb_sipo_row_feeder;
  localparam int unsigned NUM  = 3;
  localparam int unsigned AW   = 10;
  localparam int unsigned RW   = 8;
  localparam int unsigned IW   = 32;
  localparam int          MAXC = 600;
`ifdef SIPO_FEED_ZERO_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, consumer_ready;
  logic [AW-1:0] base_addr, row_stride;
  logic [RW-1:0] num_rows;
  logic          busy, done, begin_serial_in, refresh_parallel_array;
  logic [IW-1:0] in_serial;

  sipo_row_feeder_if #(.ADDR_WIDTH(AW), .IN_WIDTH(IW)) rd_bus ();

  sipo_row_feeder #(
    .IN_WIDTH(IW), .NUM(NUM), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .base_addr              (base_addr),
    .row_stride             (row_stride),
    .num_rows               (num_rows),
    .consumer_ready         (consumer_ready),
    .busy                   (busy),
    .done                   (done),
    .rd_bus                 (rd_bus),
    .in_serial              (in_serial),
    .begin_serial_in        (begin_serial_in),
    .refresh_parallel_array (refresh_parallel_array)
  );

  always #5 clk = ~clk;

  // Row buffer: one-cycle read latency, garbage when no read was issued.
  logic [IW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (rd_bus.rd_en) rd_bus.rd_data <= mem[rd_bus.rd_addr];
    else              rd_bus.rd_data <= $urandom;
  end

  int            n_vec = 0;
  int            n_err = 0;
  logic [IW-1:0] last_serial;

  bit            rdy    [MAXC];
  bit            e_en   [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  bit            e_wv   [MAXC];
  logic [IW-1:0] e_word [MAXC];
  logic [IW-1:0] e_ser  [MAXC];
  bit            e_beg  [MAXC];
  bit            e_ref  [MAXC];

  task automatic run_job(input int rows, input int pct, input int low_from, input int low_to,
                         input bit extra_start, input logic [AW-1:0] base,
                         input logic [AW-1:0] stride, input string name);
    int          total, t, tl, lastread, done_t, end_t, rr;
    bit          pad, exp_busy;
    logic [31:0] ai;
    for (int i = 0; i < MAXC; i++) begin
      rdy[i] = (i > 300) ? 1'b1 : ($urandom_range(99) < pct);
      if (i >= low_from && i <= low_to) rdy[i] = 1'b0;
      e_en[i] = 0; e_addr[i] = '0; e_wv[i] = 0; e_word[i] = '0; e_beg[i] = 0; e_ref[i] = 0;
    end
    total    = PadEn ? rows + 2 : rows;
    lastread = 0;
    if (total > 0) begin
      t = 1;
      while (!rdy[t]) t++;
      for (int i = 0; i < total; i++) begin
        pad = PadEn && (i == 0 || i == total - 1);
        rr  = PadEn ? i - 1 : i;
        for (int k = 0; k < int'(NUM); k++) begin
          ai             = base + rr * stride + k;
          e_en[t+k]      = !pad;
          e_addr[t+k]    = ai[AW-1:0];
          e_wv[t+k+2]    = 1;
          e_word[t+k+2]  = pad ? '0 : mem[ai[AW-1:0]];
          e_beg[t+k+2]   = (k == 0);
        end
        tl           = t + NUM - 1;
        e_ref[tl+3]  = 1;
        lastread     = tl;
        if (i < total - 1) begin
          t = tl + 1;
          if (!rdy[tl]) while (!rdy[t]) t++;
        end
      end
    end
    done_t   = (total == 0) ? 2 : lastread + 4;
    end_t    = done_t + 2;
    e_ser[0] = last_serial;
    for (int i = 1; i <= end_t; i++) e_ser[i] = e_wv[i] ? e_word[i] : e_ser[i-1];

    for (int c = 0; c <= end_t; c++) begin
      @(posedge clk);
      #1;
      start          = (c == 0) || (extra_start && c == 3 && total > 0);
      consumer_ready = rdy[c];
      if (c == 0) begin
        base_addr = base; row_stride = stride; num_rows = RW'(rows);
      end else begin
        base_addr = AW'($urandom); row_stride = AW'($urandom); num_rows = RW'($urandom);
      end
      @(negedge clk);
      n_vec++;
      if (rd_bus.rd_en !== e_en[c]) begin
        n_err++;
        $display("FAIL %s c=%0d rd_en got %b want %b", name, c, rd_bus.rd_en, e_en[c]);
      end
      if (e_en[c]) begin
        n_vec++;
        if (rd_bus.rd_addr !== e_addr[c]) begin
          n_err++;
          $display("FAIL %s c=%0d rd_addr got %h want %h", name, c, rd_bus.rd_addr, e_addr[c]);
        end
      end
      n_vec++;
      if (in_serial !== e_ser[c]) begin
        n_err++;
        $display("FAIL %s c=%0d in_serial got %h want %h", name, c, in_serial, e_ser[c]);
      end
      n_vec++;
      if (begin_serial_in !== e_beg[c]) begin
        n_err++;
        $display("FAIL %s c=%0d begin got %b want %b", name, c, begin_serial_in, e_beg[c]);
      end
      n_vec++;
      if (refresh_parallel_array !== e_ref[c]) begin
        n_err++;
        $display("FAIL %s c=%0d refresh got %b want %b", name, c, refresh_parallel_array,
                 e_ref[c]);
      end
      n_vec++;
      if (done !== (c == done_t)) begin
        n_err++;
        $display("FAIL %s c=%0d done got %b want %b", name, c, done, (c == done_t));
      end
      if (c != done_t) begin
        exp_busy = (c >= 1 && c < done_t);
        n_vec++;
        if (busy !== exp_busy) begin
          n_err++;
          $display("FAIL %s c=%0d busy got %b want %b", name, c, busy, exp_busy);
        end
      end
    end
    last_serial = e_ser[end_t];
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; consumer_ready = 1'b0;
    base_addr = '0; row_stride = '0; num_rows = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy, done, rd_bus.rd_en, begin_serial_in, refresh_parallel_array, rd_bus.rd_addr,
         in_serial} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b addr=%h ser=%h want all 0",
               busy, done, rd_bus.rd_en, rd_bus.rd_addr, in_serial);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    last_serial = '0;
  endtask

  task automatic test_basic();
    run_job(2, 100, -1, -1, 0, 10'h010, 10'h008, "basic");
  endtask

  task automatic test_wait();
    run_job(2, 100, 3, 6, 0, 10'h010, 10'h008, "wait");
  endtask

  task automatic test_zero_rows();
    run_job(0, 100, -1, -1, 1, 10'h123, 10'h005, "zero_rows");
  endtask

  task automatic test_wrap();
    run_job(1, 100, -1, -1, 0, 10'h3FE, 10'h001, "wrap");
  endtask

  task automatic test_back_to_back();
    run_job(5, 100, -1, -1, 1, AW'($urandom), AW'($urandom), "back_to_back");
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0); consumer_ready = 1'b1; reset = (c == 5);
      base_addr = 10'h040; row_stride = 10'h010; num_rows = 8'd3;
    end
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, rd_bus.rd_en, begin_serial_in, refresh_parallel_array, rd_bus.rd_addr,
         in_serial} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs got busy=%b done=%b rd_en=%b addr=%h ser=%h want all 0",
               busy, done, rd_bus.rd_en, rd_bus.rd_addr, in_serial);
    end
    repeat (8) begin
      @(negedge clk);
      n_vec++;
      if ({refresh_parallel_array, done, rd_bus.rd_en, begin_serial_in} !== 4'b0) begin
        n_err++;
        $display("FAIL mid_reset_quiet got refresh=%b done=%b rd_en=%b begin=%b want 0",
                 refresh_parallel_array, done, rd_bus.rd_en, begin_serial_in);
      end
    end
    last_serial = '0;
    run_job(2, 100, -1, -1, 0, 10'h040, 10'h010, "after_reset");
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(5)), int'($urandom_range(100, 30)), -1, -1, 1,
              AW'($urandom), AW'($urandom), "random");
    end
  endtask

`ifdef SIPO_FEED_ZERO_PAD_EN
  task automatic test_zero_pad();
    run_job(1, 100, -1, -1, 0, 10'h200, 10'h004, "zero_pad");
    run_job(2, 60, -1, -1, 1, 10'h3F0, 10'h00C, "zero_pad_ready");
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_wait();
    test_zero_rows();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef SIPO_FEED_ZERO_PAD_EN
    test_zero_pad();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sipo_row_feeder.md
# sipo_row_feeder

Row-fetch controller that sits directly upstream of the activation/weight serial-in/parallel-out shift bar. On each start it walks a rectangular region of the on-chip row buffer. For every row it issues NUM consecutive single-word reads and streams the returned words as `in_serial`, with a `begin_serial_in` pulse on each row's first word. Once a row is fully shifted into the bar, it pulses `refresh_parallel_array` so the row is latched into the bar's output array for the PE array.

## Interface
- `IN_WIDTH`, default `DATA_WIDTH*IF_WIDTH`: width of one buffer word and of `in_serial`.
- `NUM`, default `KERNEL_WIDTH`: words per row; equals the bar's OUT_WIDTH/IN_WIDTH. Must be ≥ 2.
- `ADDR_WIDTH`, default 10: row-buffer address width.
- `ROW_WIDTH`, default 8: width of the row count.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  address of row 0, word 0; sampled with `start`.
- `row_stride`  in  ADDR_WIDTH  address step between rows; sampled with `start`.
- `num_rows`  in  ROW_WIDTH  rows to stream; sampled with `start`.
- `consumer_ready`  in  1  level; high means the consumer can accept a refresh NUM+2 cycles later.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `rd_en`  out  1  buffer read strobe.
- `rd_addr`  out  ADDR_WIDTH  buffer read address.
- `rd_data`  in  IN_WIDTH  buffer data, valid exactly 1 cycle after `rd_en`.
- `in_serial`  out  IN_WIDTH  word to the bar.
- `begin_serial_in`  out  1  first-word-of-row pulse to the bar.
- `refresh_parallel_array`  out  1  latch pulse to the bar.

## Operation
- FSM states:
  - IDLE: `start` latches the parameters. If `num_rows`=0, go to DONE; otherwise go to WAIT.
  - WAIT: `rd_en`=0. Go to FETCH on the first cycle with `consumer_ready`=1; that cycle issues word 0.
  - FETCH: issue one read per cycle, with word counter k running 0..NUM-1 and row counter r.
    - On k=NUM-1 of the last row, go to DRAIN.
    - On k=NUM-1 of any other row: if `consumer_ready`=1, continue in FETCH with word 0 of the next row (back-to-back, no bubble); otherwise go to WAIT.
  - DRAIN: hold until the final refresh has been issued, then go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Address: `rd_addr` = base_addr + r*row_stride + k, computed incrementally (row pointer plus k), modulo 2^ADDR_WIDTH. Wrap-around is silent.
- A row's fetch starts only when `consumer_ready`=1. Its refresh then fires unconditionally NUM+2 cycles later; the ready level is not rechecked.
- `start` while `busy` is ignored.
- Reset at any point: the FSM returns to IDLE, the pipeline is flushed, and all outputs are 0 from the cycle after the reset edge. An in-flight row is discarded, with no refresh and no `done`.
- Reset values: `busy`, `done`, `rd_en`, `rd_addr`, `in_serial`, `begin_serial_in` and `refresh_parallel_array` are all 0.

## Timing
- A read issued at cycle c puts its word on `in_serial` at c+2 (read latency plus an output register). `begin_serial_in`=1 at c+2 when k=0.
- Row words occupy NUM consecutive cycles on `in_serial`. `begin_serial_in` is never asserted on non-first words.
- `refresh_parallel_array` pulses the cycle after a row's last word is on `in_serial` (c_last+3). This may coincide with the next row's `begin_serial_in`; the bar latches the completed row on that same edge.
- With `consumer_ready` held high, the row period is NUM cycles and N rows complete in N*NUM+3 cycles from FETCH entry to final refresh. `done` follows one cycle later.
- `in_serial` holds its last value when no word is valid. `begin_serial_in` and `refresh_parallel_array` are 0 outside their pulses.

## Configuration
- `SIPO_FEED_ZERO_PAD_EN` defined:
  - A virtual all-zero row is streamed before row 0 and after the last row, for num_rows+2 rows in total.
  - Pad rows follow identical timing and ready rules, but assert no `rd_en`; `in_serial`=0 for all NUM words.
  - `num_rows`=0 still produces the two pad rows.
- Not defined: exactly `num_rows` fetched rows and no pad logic.

## Structure
- The shared package / `def_params.vh` holds:
  - FSM state encodings (IDLE, WAIT, FETCH, DRAIN, DONE).
  - The read-latency constant (1).
  - `C_LOG_2`, used for the k-counter width.
- One sub-module, `sipo_feed_pipe`: a 2-stage delay line carrying {valid, first, last, pad} alongside the data, producing `in_serial`, `begin_serial_in` and `refresh_parallel_array`.

## Test plan
- NUM=3, base=0x010, stride=0x008, num_rows=2, ready=1:
  - `rd_addr` sequence is 010,011,012,018,019,01A on consecutive cycles.
  - Two `begin_serial_in` pulses, 3 cycles apart.
  - Refresh fires at the last-word cycle+1 of each row; `done` fires 1 cycle after the second refresh.
- ready low after row 0: FSM enters WAIT with `rd_en`=0; row 1's first read occurs on the cycle ready rises.
- num_rows=0, macro off: `done` 2 cycles after `start`; no `rd_en`, no begin, no refresh.
- base=0x3FE, stride=1, NUM=3, ADDR_WIDTH=10: addresses 3FE,3FF,000 (wrap).
- Reset asserted mid-row 1: all outputs 0 next cycle, no refresh, no `done`; a subsequent `start` streams correctly from row 0.
- Macro on, num_rows=1: three rows streamed (zeros, data, zeros), with exactly NUM `rd_en` pulses in total.
